// File: rtl/wb_arbiter_pkg.sv
// Shared core types for the writeback arbiter.
// Holds register width, address width and the writeback request bundle.
package wb_arbiter_pkg;

    localparam int CORE_XLEN = 32;
    localparam int REG_AW    = 5;

    typedef struct packed {
        logic [REG_AW-1:0]    rd;
        logic [CORE_XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Mul/div result queue for the writeback arbiter.
// In-order FIFO with a per-entry destination match for hazard queries.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_req_t                  push_req,
    input  logic                     pop,
    output wb_req_t                  head_req,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [REG_AW-1:0]        match_addr,
    output logic                     match
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t       mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic [PW-1:0] offs;
    logic          do_push;
    logic          do_pop;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign head_req = mem[head];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) tail <= tail + PW'(1);
            if (do_pop)  head <= head + PW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; validity comes from head and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_req;
    end

    // An entry is live when its distance from head is below count.
    always_comb begin
        match = 1'b0;
        offs  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - head;
            if ((CW'(offs) < cnt) && (mem[i].rd == match_addr))
                match = 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback port arbiter between the ALU and the mul/div unit.
// ALU has priority; mul/div results wait in a small in-order queue.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN  = CORE_XLEN,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [4:0]        md_rd,
    input  logic [XLEN-1:0]   md_data,
    input  logic [4:0]        hz_addr,
    output logic              hz_busy,
    output logic              w_en,
    output logic [4:0]        w_addr,
    output logic [XLEN-1:0]   w_data
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_req_t       push_req;
    wb_req_t       head_req;
    logic          accept;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          fifo_match;
    logic [CW-1:0] count;

    assign md_ready = (count < CW'(DEPTH));
    assign accept   = md_valid && md_ready;
    assign push     = accept && (md_rd != '0) && !full;
    assign pop      = !alu_valid && !empty;

    assign push_req.rd   = md_rd;
    assign push_req.data = md_data;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_req   (push_req),
        .pop        (pop),
        .head_req   (head_req),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .match_addr (hz_addr),
        .match      (fifo_match)
    );

    // Busy covers queued entries and a result being accepted right now.
    always_comb begin
        hz_busy = 1'b0;
        if (rst && (hz_addr != '0))
            hz_busy = fifo_match || (accept && (md_rd == hz_addr));
    end

    // Registered write port; address and data hold while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_en   <= 1'b0;
            w_addr <= '0;
            w_data <= '0;
        end else if (alu_valid) begin
            w_en <= (alu_rd != '0);
            if (alu_rd != '0) begin
                w_addr <= alu_rd;
                w_data <= alu_data;
            end
        end else if (pop) begin
            w_en   <= 1'b1;
            w_addr <= head_req.rd;
            w_data <= head_req.data;
        end else begin
            w_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for the writeback arbiter.
// Queue-based reference model plus directed scenarios.
module tb_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alu_valid = 1'b0;
    logic [4:0]      alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            md_valid = 1'b0;
    logic            md_ready;
    logic [4:0]      md_rd = '0;
    logic [XLEN-1:0] md_data = '0;
    logic [4:0]      hz_addr = '0;
    logic            hz_busy;
    logic            w_en;
    logic [4:0]      w_addr;
    logic [XLEN-1:0] w_data;

    always #5 clk = ~clk;

    wb_arbiter #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .md_valid  (md_valid),
        .md_ready  (md_ready),
        .md_rd     (md_rd),
        .md_data   (md_data),
        .hz_addr   (hz_addr),
        .hz_busy   (hz_busy),
        .w_en      (w_en),
        .w_addr    (w_addr),
        .w_data    (w_data)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    ent_t        src[$];
    logic [4:0]  wlog[$];
    int          checks = 0;
    int          errors = 0;
    logic        exp_en = 1'b0;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive, check combinational outputs, advance model,
    // then check the registered write port after the edge.
    task automatic cyc(input logic av, input logic [4:0] ar,
                       input logic [31:0] ad, input logic [4:0] ha);
        logic acc;
        logic busy;
        ent_t e;
        alu_valid = av;
        alu_rd    = ar;
        alu_data  = ad;
        hz_addr   = ha;
        md_valid  = (src.size() > 0);
        md_rd     = md_valid ? src[0].rd : 5'd0;
        md_data   = md_valid ? src[0].data : 32'd0;
        #1;
        acc  = md_valid && (q.size() < DEPTH);
        busy = 1'b0;
        if (ha != 0) begin
            foreach (q[i]) if (q[i].rd == ha) busy = 1'b1;
            if (acc && md_rd == ha) busy = 1'b1;
        end
        chk("md_ready", 32'(md_ready), 32'(q.size() < DEPTH));
        chk("hz_busy", 32'(hz_busy), 32'(busy));
        if (av) begin
            exp_en = (ar != 0);
            if (ar != 0) begin
                exp_addr = ar;
                exp_data = ad;
            end
        end else if (q.size() > 0) begin
            exp_en   = 1'b1;
            exp_addr = q[0].rd;
            exp_data = q[0].data;
            void'(q.pop_front());
        end else begin
            exp_en = 1'b0;
        end
        if (acc) begin
            e = src.pop_front();
            if (e.rd != 0) q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("w_en", 32'(w_en), 32'(exp_en));
        chk("w_addr", 32'(w_addr), 32'(exp_addr));
        chk("w_data", w_data, exp_data);
        if (w_en) wlog.push_back(w_addr);
    endtask

    task automatic idle(input int n, input logic [4:0] ha);
        for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, ha);
    endtask

    initial begin
        #2;
        chk("rst_w_en", 32'(w_en), 32'd0);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_w_data", w_data, 32'd0);
        chk("rst_md_ready", 32'(md_ready), 32'd1);
        chk("rst_hz_busy", 32'(hz_busy), 32'd0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ALU write, latency one
        cyc(1'b1, 5'd5, 32'h1234, 5'd0);
        chk("alu_lat_en", 32'(w_en), 32'd1);
        chk("alu_lat_addr", 32'(w_addr), 32'd5);
        chk("alu_lat_data", w_data, 32'h1234);

        // Mul/div write, latency two, hazard visible until popped
        src.push_back('{5'd7, 32'hBEEF});
        cyc(1'b0, 5'd0, 32'd0, 5'd7);
        chk("md_lat1_en", 32'(w_en), 32'd0);
        #3;
        chk("md_hz_queued", 32'(hz_busy), 32'd1);
        #1;
        cyc(1'b0, 5'd0, 32'd0, 5'd7);
        chk("md_lat2_en", 32'(w_en), 32'd1);
        chk("md_lat2_addr", 32'(w_addr), 32'd7);
        chk("md_lat2_data", w_data, 32'hBEEF);
        #3;
        chk("md_hz_clear", 32'(hz_busy), 32'd0);
        #1;
        idle(1, 5'd7);

        // ALU starvation with three mul/div results waiting
        src.push_back('{5'd3, 32'h33});
        src.push_back('{5'd4, 32'h44});
        src.push_back('{5'd9, 32'h99});
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 5'(10 + i), 32'(100 + i), 5'd9);
        chk("starve_pending", 32'(src.size()), 32'd1);
        wlog.delete();
        idle(5, 5'd4);
        chk("starve_cnt", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            chk("starve_w0", 32'(wlog[0]), 32'd3);
            chk("starve_w1", 32'(wlog[1]), 32'd4);
            chk("starve_w2", 32'(wlog[2]), 32'd9);
        end

        // x0 destinations are never written
        wlog.delete();
        src.push_back('{5'd0, 32'h55});
        cyc(1'b1, 5'd0, 32'hDEAD, 5'd0);
        idle(3, 5'd0);
        chk("x0_writes", 32'(wlog.size()), 32'd0);
        chk("x0_drained", 32'(src.size()), 32'd0);

        // Full queue: pop and offer together, push next cycle
        src.push_back('{5'd1, 32'h11});
        src.push_back('{5'd2, 32'h22});
        cyc(1'b1, 5'd20, 32'hA0, 5'd2);
        cyc(1'b1, 5'd21, 32'hA1, 5'd2);
        src.push_back('{5'd6, 32'h66});
        cyc(1'b0, 5'd0, 32'd0, 5'd6);
        chk("full_no_push", 32'(src.size()), 32'd1);
        cyc(1'b1, 5'd22, 32'hA2, 5'd6);
        chk("full_refill", 32'(q.size()), 32'd2);
        idle(3, 5'd6);

        // Reset mid-operation with two entries queued
        src.push_back('{5'd11, 32'hB1});
        src.push_back('{5'd12, 32'hB2});
        cyc(1'b1, 5'd20, 32'hC0, 5'd0);
        cyc(1'b1, 5'd21, 32'hC1, 5'd0);
        md_valid = 1'b1;
        md_rd    = 5'd11;
        hz_addr  = 5'd11;
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_w_en", 32'(w_en), 32'd0);
        chk("mrst_w_addr", 32'(w_addr), 32'd0);
        chk("mrst_w_data", w_data, 32'd0);
        chk("mrst_md_ready", 32'(md_ready), 32'd1);
        chk("mrst_hz_busy", 32'(hz_busy), 32'd0);
        q.delete();
        src.delete();
        exp_en   = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        md_valid  = 1'b0;
        alu_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_w_en", 32'(w_en), 32'd0);
        wlog.delete();
        idle(3, 5'd11);
        chk("post_rst_writes", 32'(wlog.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
